// File: rtl/bnn_inference_ctrl.sv
// Sequencer between the image buffer, the BNN core and the result consumer:
// start on a full frame, wait for done with a timeout, hand the digit over, flush.
module bnn_inference_ctrl #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13,
  parameter int RESULT_W       = 4,
  parameter int ICNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                img_buffer_full,
  output logic                img_buffer_clear,
  output logic                bnn_start,
  input  logic                bnn_done,
  input  logic [RESULT_W-1:0] bnn_result,
  output logic [RESULT_W-1:0] result_out,
  output logic                result_valid,
  input  logic                result_ack,
  output logic                busy,
  output logic                timeout_err,
  input  logic                err_clear,
  output logic [ICNT_W-1:0]   infer_count,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_CLEAR = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RESULT_W-1:0]   result_q, result_d;
  logic [ICNT_W-1:0]     icnt_q, icnt_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  start_q, start_d;
  logic                  clear_q, clear_d;
  logic                  busy_q, busy_d;
  logic                  err_set;

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    icnt_d   = icnt_q;
    valid_d  = valid_q;
    err_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (img_buffer_full) state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done on the last allowed cycle still counts as a success.
        if (bnn_done) begin
          result_d = bnn_result;
          valid_d  = 1'b1;
          icnt_d   = icnt_q + ICNT_W'(1);
          state_d  = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_set = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_HOLD: begin
        if (result_ack) begin
          valid_d = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!img_buffer_full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (err_set)        err_d = 1'b1;
    else if (err_clear) err_d = 1'b0;
    else                err_d = err_q;

    // State-decoded outputs come from the next state so they are registered yet cycle-aligned.
    start_d = (state_d == S_START);
    clear_d = (state_d == S_CLEAR);
    busy_d  = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      icnt_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      clear_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      icnt_q   <= icnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      start_q  <= start_d;
      clear_q  <= clear_d;
      busy_q   <= busy_d;
    end
  end

  assign img_buffer_clear = clear_q;
  assign bnn_start        = start_q;
  assign result_out       = result_q;
  assign result_valid     = valid_q;
  assign busy             = busy_q;
  assign timeout_err      = err_q;
  assign infer_count      = icnt_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_bnn_inference_ctrl.sv
// Directed bench for bnn_inference_ctrl: table of frame scenarios plus hand-written
// sequences for error clearing, asynchronous reset and counter wrap.
module tb_bnn_inference_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       img_buffer_full;
  logic       img_buffer_clear;
  logic       bnn_start;
  logic       bnn_done;
  logic [3:0] bnn_result;
  logic [3:0] result_out;
  logic       result_valid;
  logic       result_ack;
  logic       busy;
  logic       timeout_err;
  logic       err_clear;
  logic [7:0] infer_count;
  logic [2:0] state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_icnt;
  logic       exp_err;
  logic [3:0] exp_res;

  bnn_inference_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(5),
    .RESULT_W(4),
    .ICNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .img_buffer_full(img_buffer_full),
    .img_buffer_clear(img_buffer_clear),
    .bnn_start(bnn_start),
    .bnn_done(bnn_done),
    .bnn_result(bnn_result),
    .result_out(result_out),
    .result_valid(result_valid),
    .result_ack(result_ack),
    .busy(busy),
    .timeout_err(timeout_err),
    .err_clear(err_clear),
    .infer_count(infer_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         done_dly;   // WAIT cycles before done; >= TO means never
    logic [3:0] res;
    int         ack_dly;
    int         clr_hold;   // CLEAR cycles with full still high
    logic [3:0] exp_result; // result_out back in IDLE
    logic       exp_err;    // timeout_err back in IDLE
  } vec_t;

  vec_t rows [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " state"},  32'(state_dbg), 0);
    check({tag, " start"},  32'(bnn_start), 0);
    check({tag, " clear"},  32'(img_buffer_clear), 0);
    check({tag, " valid"},  32'(result_valid), 0);
    check({tag, " err"},    32'(timeout_err), 0);
    check({tag, " busy"},   32'(busy), 0);
    check({tag, " result"}, 32'(result_out), 0);
    check({tag, " icnt"},   32'(infer_count), 0);
  endtask

  // Runs one frame from IDLE back to IDLE; img_buffer_full is left low.
  task automatic do_frame(input int done_dly, input logic [3:0] res, input int ack_dly,
                          input int clr_hold, input logic [3:0] exp_result, input logic exp_e);
    img_buffer_full = 1'b1;
    tick();
    check("start pulse", 32'(bnn_start), 1);
    check("start state", 32'(state_dbg), 1);
    check("start busy", 32'(busy), 1);
    tick();
    check("wait state", 32'(state_dbg), 2);
    check("start one cycle", 32'(bnn_start), 0);
    if (done_dly >= TO) begin
      repeat (TO - 1) tick();
      check("wait before timeout", 32'(state_dbg), 2);
      check("err before timeout", 32'(timeout_err), 32'(exp_err));
      tick();
      exp_err = 1'b1;
      check("timeout state", 32'(state_dbg), 4);
      check("timeout err", 32'(timeout_err), 1);
      check("timeout no valid", 32'(result_valid), 0);
      check("timeout icnt", 32'(infer_count), 32'(exp_icnt));
      check("timeout result kept", 32'(result_out), 32'(exp_res));
    end else begin
      repeat (done_dly) tick();
      bnn_done = 1'b1;
      bnn_result = res;
      tick();
      bnn_done = 1'b0;
      bnn_result = 4'd0;
      exp_icnt = exp_icnt + 8'd1;
      exp_res = res;
      check("hold state", 32'(state_dbg), 3);
      check("hold valid", 32'(result_valid), 1);
      check("hold result", 32'(result_out), 32'(res));
      check("hold icnt", 32'(infer_count), 32'(exp_icnt));
      check("hold err", 32'(timeout_err), 32'(exp_err));
      for (int i = 0; i < ack_dly; i++) begin
        img_buffer_full = i[0];
        tick();
        check("hold wait valid", 32'(result_valid), 1);
        check("hold wait result", 32'(result_out), 32'(res));
        check("hold no restart", 32'(bnn_start), 0);
        check("hold wait state", 32'(state_dbg), 3);
      end
      img_buffer_full = 1'b1;
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check("ack state", 32'(state_dbg), 4);
      check("ack valid low", 32'(result_valid), 0);
      check("ack result kept", 32'(result_out), 32'(res));
    end
    check("clear asserted", 32'(img_buffer_clear), 1);
    for (int i = 0; i < clr_hold; i++) begin
      tick();
      check("clear held state", 32'(state_dbg), 4);
      check("clear held", 32'(img_buffer_clear), 1);
    end
    img_buffer_full = 1'b0;
    tick();
    check("idle state", 32'(state_dbg), 0);
    check("idle busy", 32'(busy), 0);
    check("idle clear low", 32'(img_buffer_clear), 0);
    check("idle result", 32'(result_out), 32'(exp_result));
    check("idle err", 32'(timeout_err), 32'(exp_e));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] icnt_start;

    rows[0] = '{12, 4'd7,  0, 0, 4'd7,  1'b0};
    rows[1] = '{15, 4'd9,  1, 0, 4'd9,  1'b0};  // done on the last WAIT cycle
    rows[2] = '{0,  4'd3, 50, 0, 4'd3,  1'b0};  // slow consumer, full toggling in HOLD
    rows[3] = '{4,  4'd12, 2, 3, 4'd12, 1'b0};  // full held 3 cycles in CLEAR
    rows[4] = '{TO, 4'd5,  0, 0, 4'd12, 1'b1};  // timeout, result kept
    rows[5] = '{0,  4'd1,  0, 0, 4'd1,  1'b1};  // frame after timeout, error sticky

    rst_n = 1'b1;
    img_buffer_full = 1'b0;
    bnn_done = 1'b0;
    bnn_result = 4'd0;
    result_ack = 1'b0;
    err_clear = 1'b0;
    exp_icnt = 8'd0;
    exp_err = 1'b0;
    exp_res = 4'd0;

    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle after reset", 32'(state_dbg), 0);

    for (int r = 0; r < 6; r++)
      do_frame(rows[r].done_dly, rows[r].res, rows[r].ack_dly, rows[r].clr_hold,
               rows[r].exp_result, rows[r].exp_err);

    // err_clear pulse clears the sticky flag
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    exp_err = 1'b0;
    check("err cleared", 32'(timeout_err), 0);

    // err_clear held through a timeout: set wins on the timeout edge
    img_buffer_full = 1'b1;
    tick();
    tick();
    err_clear = 1'b1;
    repeat (TO) tick();
    check("set wins state", 32'(state_dbg), 4);
    check("set wins err", 32'(timeout_err), 1);
    tick();
    check("clear after set", 32'(timeout_err), 0);
    check("clear waits full", 32'(state_dbg), 4);
    err_clear = 1'b0;
    img_buffer_full = 1'b0;
    tick();
    check("idle after set-clear", 32'(state_dbg), 0);

    // Leave a sticky error and a nonzero count before the mid-WAIT reset
    do_frame(TO, 4'd0, 0, 0, exp_res, 1'b1);
    img_buffer_full = 1'b1;
    tick();
    tick();
    repeat (3) tick();
    rst_n = 1'b0;
    #1 check_reset_outputs("rst mid wait");
    img_buffer_full = 1'b0;
    exp_icnt = 8'd0;
    exp_err = 1'b0;
    exp_res = 4'd0;
    #2 rst_n = 1'b1;
    tick();
    do_frame(2, 4'd6, 0, 0, 4'd6, 1'b0);

    img_buffer_full = 1'b1;
    tick();
    tick();
    bnn_done = 1'b1;
    bnn_result = 4'd11;
    tick();
    bnn_done = 1'b0;
    check("pre-reset hold valid", 32'(result_valid), 1);
    check("pre-reset icnt", 32'(infer_count), 2);
    rst_n = 1'b0;
    #1 check_reset_outputs("rst mid hold");
    img_buffer_full = 1'b0;
    exp_icnt = 8'd0;
    exp_res = 4'd0;
    #2 rst_n = 1'b1;
    tick();
    do_frame(1, 4'd2, 0, 0, 4'd2, 1'b0);

    // 256 back-to-back frames: the count wraps through 255 -> 0 back to its start
    icnt_start = exp_icnt;
    for (int f = 0; f < 256; f++) begin
      logic [3:0] r4;
      r4 = 4'(f);
      do_frame(0, r4, 0, 0, r4, 1'b0);
    end
    check("wrap full circle", 32'(infer_count), 32'(icnt_start));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_inference_ctrl.md
Name: bnn_inference_ctrl

Overview:
- Sequencer between the image buffer, the BNN core and the result consumer (UART/host side).
- Detects a full image buffer and issues a one-cycle start to the core.
- Waits for core done, with a timeout, then latches the digit result and presents it on a valid/ack handshake.
- Clears the image buffer for the next frame, and keeps a sticky timeout error and a wrapping inference counter.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum WAIT_BNN cycles before abort; must be ≥2.
- CNT_W, 13: timeout counter width; must satisfy 2^CNT_W ≥ TIMEOUT_CYCLES.
- RESULT_W, 4: width of the class index from the core.
- ICNT_W, 8: width of the completed-inference counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- img_buffer_full  in  1  image buffer holds a complete frame (level).
- img_buffer_clear  out  1  request buffer flush; held high during CLEAR.
- bnn_start  out  1  one-cycle start pulse to the BNN core.
- bnn_done  in  1  core result valid (pulse or level; sampled only in WAIT_BNN).
- bnn_result  in  RESULT_W  core class index, valid when bnn_done=1.
- result_out  out  RESULT_W  latched class index.
- result_valid  out  1  result_out is valid; held until accepted.
- result_ack  in  1  consumer accepts result (sampled only in HOLD).
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky flag: the core failed to finish in time.
- err_clear  in  1  clears timeout_err.
- infer_count  out  ICNT_W  number of successful inferences, wrapping.
- state_dbg  out  3  encoding of the current state.

Behaviour:
- Reset (async, rst_n=0), effective immediately, including mid-inference:
  - state=IDLE.
  - bnn_start, img_buffer_clear, result_valid, timeout_err, busy = 0.
  - result_out=0, infer_count=0, timeout counter=0.
- All outputs are registered. state_dbg encoding: IDLE=0, START=1, WAIT_BNN=2, HOLD=3, CLEAR=4.
- IDLE: img_buffer_full=1 at edge k → START at k+1; otherwise stay.
- START: exactly one cycle.
  - bnn_start=1 for that cycle only; the timeout counter loads 0.
  - Next state is WAIT_BNN unconditionally.
- WAIT_BNN: the counter increments every cycle.
  - If bnn_done=1:
    - result_out<=bnn_result, result_valid<=1, infer_count<=infer_count+1 (modulo 2^ICNT_W).
    - Next state is HOLD.
  - Else, if counter==TIMEOUT_CYCLES-1:
    - timeout_err<=1, result_valid stays 0, infer_count unchanged.
    - Next state is CLEAR.
  - bnn_done and timeout condition in the same cycle: done wins, no error.
- HOLD: result_valid=1 and result_out stable.
  - result_ack=1 at an edge → result_valid<=0 → CLEAR.
  - An ack already high on entry is honoured on the first HOLD edge, giving a minimum HOLD of 1 cycle.
- CLEAR: img_buffer_clear=1 in every CLEAR cycle.
  - Exit to IDLE on the first edge where img_buffer_full=0.
  - This prevents restarting on a stale full flag.
  - img_buffer_clear deasserts in IDLE.
- result_out keeps its last value after the handshake until the next capture.
- bnn_start never asserts outside START.
- busy=1 in START, WAIT_BNN, HOLD and CLEAR.
- timeout_err behaviour:
  - Set only from WAIT_BNN; cleared by err_clear=1 in any state.
  - Set and clear in the same cycle: set wins.
  - A timeout does not block further frames.
- Minimum latency:
  - Full at edge k → bnn_start high in cycle k+1.
  - Done seen at edge j → result_valid high from j+1.
- The img_buffer_full and bnn_done level/pulse inputs are ignored outside the states that sample them.
- Latency bound: WAIT_BNN lasts at most TIMEOUT_CYCLES cycles.

Test Plan:
- Reset, then assert img_buffer_full:
  - bnn_start is a single-cycle pulse one clock later.
  - Core returns bnn_done with bnn_result=4'd7 after 20 cycles → result_valid=1, result_out=7, infer_count=1.
  - Ack → result_valid low, img_buffer_clear high until full drops, then IDLE with busy=0.
- Timeout with TIMEOUT_CYCLES=16 and no bnn_done:
  - timeout_err=1 exactly 16 cycles after WAIT_BNN entry; state goes to CLEAR, infer_count unchanged.
  - A later err_clear pulse → timeout_err=0.
- bnn_done asserted on the final WAIT_BNN cycle (counter=15): result captured, timeout_err stays 0.
- Consumer delays ack by 50 cycles:
  - result_valid and result_out stay stable throughout.
  - img_buffer_full toggling in HOLD causes no new bnn_start.
- rst_n dropped mid-WAIT_BNN and mid-HOLD: all outputs are 0 asynchronously (before the next clock edge); a new frame after release runs normally.
- 256 back-to-back inferences with ICNT_W=8:
  - infer_count wraps 255→0.
  - img_buffer_full held high in CLEAR for 3 cycles delays the return to IDLE by exactly 3 cycles.
